// File: rtl/seq_rshift_32_pkg.sv
// Shared definitions for the sequential 32-bit right shifter:
// state encoding, datapath widths and the fill-bit helper.
package rshift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Sign-fill copies the operand MSB; zero-fill ignores it.
  function automatic logic fill_bit(input logic arith, input logic [DATA_W-1:0] operand);
    return arith & operand[DATA_W-1];
  endfunction

endpackage

// File: rtl/seq_rshift_32_if.sv
// Request/result bundle between a shift requester (master) and
// seq_rshift_32 (slave).
interface seq_rshift_32_if;
  import rshift_pkg::*;

  logic                 ctrl_shift;
  logic [DATA_W-1:0]    data_in;
  logic [SHAMT_W-1:0]   shamt;
  logic                 arith;
  logic                 busy;
  logic                 data_resultRDY;
  logic [DATA_W-1:0]    data_result;

  modport master (
    output ctrl_shift, data_in, shamt, arith,
    input  busy, data_resultRDY, data_result
  );

  modport slave (
    input  ctrl_shift, data_in, shamt, arith,
    output busy, data_resultRDY, data_result
  );

endinterface

// File: rtl/seq_rshift_32_onebit.sv
// Combinational single-position right shift with an externally supplied
// fill bit; the building block of the sequential shifter's datapath.
module onebit_rshift_32 (
  input  logic [31:0] in32,
  input  logic        fill,
  output logic [31:0] out32
);

  assign out32 = {fill, in32[31:1]};

endmodule

// File: rtl/seq_rshift_32.sv
// Multicycle 32-bit logical/arithmetic right shifter, one bit per clock.
// Define SEQ_RSHIFT_SKIP4_EN to retire four bit positions per clock while count >= 4.
module seq_rshift_32
  import rshift_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  seq_rshift_32_if.slave   bus
);

  state_t               state_r;
  state_t               state_s;
  logic [DATA_W-1:0]    work_r;
  logic [DATA_W-1:0]    work_s;
  logic [SHAMT_W-1:0]   count_r;
  logic [SHAMT_W-1:0]   count_s;
  logic                 fill_r;
  logic                 fill_s;
  logic [DATA_W-1:0]    result_r;
  logic [DATA_W-1:0]    result_s;
  logic                 rdy_r;
  logic                 rdy_s;
  logic                 busy_r;
  logic                 busy_s;
  logic [DATA_W-1:0]    step1_s;

  onebit_rshift_32 u_step1 (
    .in32  (work_r),
    .fill  (fill_r),
    .out32 (step1_s)
  );

`ifdef SEQ_RSHIFT_SKIP4_EN
  logic [DATA_W-1:0]    step2_s;
  logic [DATA_W-1:0]    step3_s;
  logic [DATA_W-1:0]    step4_s;

  onebit_rshift_32 u_step2 (
    .in32  (step1_s),
    .fill  (fill_r),
    .out32 (step2_s)
  );

  onebit_rshift_32 u_step3 (
    .in32  (step2_s),
    .fill  (fill_r),
    .out32 (step3_s)
  );

  onebit_rshift_32 u_step4 (
    .in32  (step3_s),
    .fill  (fill_r),
    .out32 (step4_s)
  );
`endif

  // Next-state, datapath update and output decode.
  always_comb begin
    state_s  = state_r;
    work_s   = work_r;
    count_s  = count_r;
    fill_s   = fill_r;
    result_s = result_r;
    rdy_s    = 1'b0;

    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.ctrl_shift) begin
          work_s  = bus.data_in;
          count_s = bus.shamt;
          fill_s  = fill_bit(bus.arith, bus.data_in);
          state_s = S_SHIFT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (count_r != 5'd0) begin
`ifdef SEQ_RSHIFT_SKIP4_EN
          if (count_r >= 5'd4) begin
            work_s  = step4_s;
            count_s = count_r - 5'd4;
          end else begin
            work_s  = step1_s;
            count_s = count_r - 5'd1;
          end
`else
          work_s  = step1_s;
          count_s = count_r - 5'd1;
`endif
          state_s = S_SHIFT;
        end else begin
          // Result register only ever loads here, so it never shows a partial shift.
          result_s = work_r;
          rdy_s    = 1'b1;
          state_s  = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    busy_s = (state_s == S_SHIFT);
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= S_IDLE;
      work_r   <= 32'h0;
      count_r  <= 5'd0;
      fill_r   <= 1'b0;
      result_r <= 32'h0;
      rdy_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      work_r   <= work_s;
      count_r  <= count_s;
      fill_r   <= fill_s;
      result_r <= result_s;
      rdy_r    <= rdy_s;
      busy_r   <= busy_s;
    end
  end

  assign bus.busy           = busy_r;
  assign bus.data_resultRDY = rdy_r;
  assign bus.data_result    = result_r;

endmodule

// File: tb/tb_seq_rshift_32.sv
// Self-checking bench for seq_rshift_32: vector table plus hand-written
// sequences (ignored start, back-to-back start, mid-op reset) and a scoreboard.
module tb_seq_rshift_32;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic        a;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          due;
  } sb_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  sb_t  sb[$];
  vec_t vecs[10];

  seq_rshift_32_if bus ();

  seq_rshift_32 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int exp_lat(input logic [4:0] s);
`ifdef SEQ_RSHIFT_SKIP4_EN
    return int'(s) / 4 + int'(s) % 4 + 1;
`else
    return int'(s) + 1;
`endif
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Scoreboard monitor: every RDY pulse must match the oldest pending op.
  always @(posedge clock) begin
    sb_t e;
    #1;
    if (bus.data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", bus.data_result, e.exp);
        check("latency", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() != 0 && cyc > sb[0].due + 4) begin
      e = sb.pop_front();
      check("rdy_timeout", 32'(cyc), 32'(e.due));
    end
  end

  task automatic start_op(input logic [31:0] d, input logic [4:0] s, input logic a, input logic [31:0] exp);
    bus.data_in    = d;
    bus.shamt      = s;
    bus.arith      = a;
    bus.ctrl_shift = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_shift = 1'b0;
    bus.data_in    = $urandom();
    bus.shamt      = 5'($urandom_range(0, 31));
    bus.arith      = ~a;
    sb.push_back('{exp, cyc + exp_lat(s)});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      check("drain_bound", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    bit seen;

    vecs[0] = '{32'h8000_00F0, 5'd4,  1'b0, 32'h0800_000F};
    vecs[1] = '{32'h8000_00F0, 5'd4,  1'b1, 32'hF800_000F};
    vecs[2] = '{32'h8000_00F0, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678};
    vecs[4] = '{32'hA5A5_A5A5, 5'd13, 1'b1, 32'hFFFD_2D2D};
    vecs[5] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
    vecs[6] = '{32'hFFFF_FFFF, 5'd1,  1'b0, 32'h7FFF_FFFF};
    vecs[7] = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000};
    vecs[8] = '{32'hA5A5_A5A5, 5'd8,  1'b0, 32'h00A5_A5A5};
    vecs[9] = '{32'hA5A5_A5A5, 5'd5,  1'b0, 32'h052D_2D2D};

    reset          = 1'b1;
    bus.ctrl_shift = 1'b0;
    bus.data_in    = 32'h0;
    bus.shamt      = 5'd0;
    bus.arith      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("reset_result", bus.data_result, 32'h0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      start_op(vecs[i].d, vecs[i].s, vecs[i].a, vecs[i].exp);
      check("busy_after_start", 32'(bus.busy), 32'd1);
      wait_drain();
      repeat (2) @(posedge clock);
      #1;
      check("hold_result", bus.data_result, vecs[i].exp);
      check("idle_busy", 32'(bus.busy), 32'd0);
    end

    // Start pulse during SHIFT is ignored; a start in the DONE cycle follows with no bubble.
    start_op(32'hF0F0_1234, 5'd10, 1'b1, 32'hFFFC_3C04);
    repeat (2) @(posedge clock);
    #1;
    bus.data_in    = 32'h0000_0001;
    bus.shamt      = 5'd0;
    bus.arith      = 1'b0;
    bus.ctrl_shift = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_shift = 1'b0;
    check("busy_in_shift", 32'(bus.busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    start_op(32'h0000_FF00, 5'd8, 1'b0, 32'h0000_00FF);
    check("no_bubble_busy", 32'(bus.busy), 32'd1);
    wait_drain();
    repeat (2) @(posedge clock);
    #1;

    // Reset in the middle of a long shift aborts it and clears the result.
    start_op(32'hDEAD_BEEF, 5'd20, 1'b0, 32'h0000_0DEA);
    repeat (2) @(posedge clock);
    #1;
    sb.delete();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("abort_result", bus.data_result, 32'h0);
    repeat (25) @(posedge clock);
    #1;
    start_op(32'h8765_4321, 5'd3, 1'b1, 32'hF0EC_A864);
    wait_drain();
    repeat (2) @(posedge clock);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
